// File: rtl/branch_retire_queue.sv
`default_nettype none
// ============================================================================
//  Module   : branch_retire_queue
//  Purpose  : In-order queue of conditional-branch prediction records.
//             Entries are allocated at dispatch, resolved by the branch unit
//             and popped at ROB retire. Popped entries drive the bht
//             retire-update port; a mispredict found at retire flushes the
//             queue and, two cycles later, drives the bht history recovery.
//  Ports    : clock / reset (async, active-low)
//             id_*      : two dispatch slots in, allocated tags and stall out
//             ex_*      : branch resolution (tag + actual direction)
//             rob_*     : two retire slots in, registered bht update out
//             recover_* : bht history restore strobe and value
//             err       : sticky protocol error
//  Revision : 1.0  initial release
// ============================================================================
module branch_retire_queue #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4,
  parameter int BHR_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid0,
  input  logic             id_valid1,
  input  logic [63:0]      id_NPC0,
  input  logic [63:0]      id_NPC1,
  input  logic [BHR_W-1:0] id_bhr0,
  input  logic [BHR_W-1:0] id_bhr1,
  input  logic             id_pred_taken0,
  input  logic             id_pred_taken1,
  output logic [IDX_W-1:0] id_tag0,
  output logic [IDX_W-1:0] id_tag1,
  output logic             id_stall,
  input  logic             ex_resolve_valid,
  input  logic [IDX_W-1:0] ex_resolve_tag,
  input  logic             ex_actual_taken,
  input  logic             rob_retire_br0,
  input  logic             rob_retire_br1,
  output logic [1:0]       rob_retire_num,
  output logic             rob_retire_cond0,
  output logic             rob_retire_cond1,
  output logic [63:0]      rob_retire_NPC0,
  output logic [63:0]      rob_retire_NPC1,
  output logic [BHR_W-1:0] rob_retire_BHR0,
  output logic [BHR_W-1:0] rob_retire_BHR1,
  output logic             rob_actual_taken0,
  output logic             rob_actual_taken1,
  output logic             recover_cond,
  output logic [BHR_W-1:0] recover_bhr,
  output logic             err
);

  localparam int CNT_W = IDX_W + 1;
  localparam logic [0:0] S_NORMAL  = 1'b0;
  localparam logic [0:0] S_RECOVER = 1'b1;

  // Entry storage: valid/resolved are reset, payload is not.
  logic [63:0]      r_npc    [DEPTH];
  logic [BHR_W-1:0] r_bhr    [DEPTH];
  logic             r_pred   [DEPTH];
  logic             r_actual [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_resolved;

  logic [0:0]       r_state, w_state_next;
  logic [IDX_W-1:0] r_head, r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_err, r_recover_cond;
  logic [BHR_W-1:0] r_recover_bhr;
  logic [1:0]       r_num;
  logic             r_cond0, r_cond1, r_act0, r_act1;
  logic [63:0]      r_npc0, r_npc1;
  logic [BHR_W-1:0] r_bhr0, r_bhr1;

  logic             w_recover, w_stall, w_enq0, w_enq1, w_drop;
  logic [1:0]       w_enq_num, w_deq_num;
  logic [IDX_W-1:0] w_tag1, w_head1;
  logic             w_pop0, w_pop1, w_misp0, w_misp1, w_flush, w_bad_pop;
  logic             w_ok0, w_ok1;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_NORMAL;
    else        r_state <= w_state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_NORMAL:  if (w_flush) w_state_next = S_RECOVER;
      S_RECOVER: w_state_next = S_NORMAL;
      default:   w_state_next = S_NORMAL;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Stall also covers the recover_cond cycle so no new branch is predicted
  // with a history that is about to be overwritten.
  always_comb begin
    w_recover = (r_state == S_RECOVER);
    w_stall   = (r_count > CNT_W'(DEPTH - 2)) | w_recover | r_recover_cond;
  end

  // ---------------- dispatch ----------------
  assign w_enq0    = id_valid0 & ~w_stall;
  assign w_enq1    = id_valid1 & ~w_stall;
  assign w_enq_num = {1'b0, w_enq0} + {1'b0, w_enq1};
  assign w_tag1    = r_tail + IDX_W'(id_valid0);   // compacted slot-1 tag
  assign w_drop    = (id_valid0 | id_valid1) & w_stall;

  // ---------------- retire ----------------
  // Only a resolved entry can mispredict; popping an unresolved one is an
  // error but must not trigger a spurious flush from stale direction bits.
  assign w_head1   = r_head + IDX_W'(1);
  assign w_ok0     = r_valid[r_head]  & r_resolved[r_head];
  assign w_ok1     = r_valid[w_head1] & r_resolved[w_head1];
  assign w_pop0    = ~w_recover & (rob_retire_br0 | rob_retire_br1);
  assign w_misp0   = w_pop0 & w_ok0 & (r_actual[r_head] != r_pred[r_head]);
  assign w_pop1    = ~w_recover & rob_retire_br0 & rob_retire_br1 & ~w_misp0;
  assign w_misp1   = w_pop1 & w_ok1 & (r_actual[w_head1] != r_pred[w_head1]);
  assign w_flush   = w_misp0 | w_misp1;
  assign w_bad_pop = (w_pop0 & ~w_ok0) | (w_pop1 & ~w_ok1);
  assign w_deq_num = {1'b0, w_pop0} + {1'b0, w_pop1};

  // ---------------- control state ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_valid        <= '0;
      r_resolved     <= '0;
      r_err          <= 1'b0;
      r_recover_cond <= 1'b0;
      r_recover_bhr  <= '0;
      r_num          <= '0;
      r_cond0        <= 1'b0;
      r_cond1        <= 1'b0;
      r_npc0         <= '0;
      r_npc1         <= '0;
      r_bhr0         <= '0;
      r_bhr1         <= '0;
      r_act0         <= 1'b0;
      r_act1         <= 1'b0;
    end else begin
      // Order matters: resolve, then pop, then allocate, then flush wins.
      if (!w_recover && ex_resolve_valid && r_valid[ex_resolve_tag])
        r_resolved[ex_resolve_tag] <= 1'b1;
      if (w_pop0) begin
        r_valid[r_head]    <= 1'b0;
        r_resolved[r_head] <= 1'b0;
      end
      if (w_pop1) begin
        r_valid[w_head1]    <= 1'b0;
        r_resolved[w_head1] <= 1'b0;
      end
      if (w_enq0) begin
        r_valid[r_tail]    <= 1'b1;
        r_resolved[r_tail] <= 1'b0;
      end
      if (w_enq1) begin
        r_valid[w_tag1]    <= 1'b1;
        r_resolved[w_tag1] <= 1'b0;
      end

      if (w_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_valid <= '0;
      end else begin
        r_head  <= r_head + IDX_W'(w_deq_num);
        r_tail  <= r_tail + IDX_W'(w_enq_num);
        r_count <= r_count + CNT_W'(w_enq_num) - CNT_W'(w_deq_num);
      end

      if (w_misp0)
        r_recover_bhr <= {r_bhr[r_head][BHR_W-2:0], r_actual[r_head]};
      else if (w_misp1)
        r_recover_bhr <= {r_bhr[w_head1][BHR_W-2:0], r_actual[w_head1]};

      r_recover_cond <= w_recover;   // one cycle after the update port
      r_err          <= r_err | w_drop | w_bad_pop;

      r_num   <= w_deq_num;
      r_cond0 <= w_pop0;
      r_cond1 <= w_pop1;
      r_npc0  <= w_pop0 ? r_npc[r_head]     : '0;
      r_bhr0  <= w_pop0 ? r_bhr[r_head]     : '0;
      r_act0  <= w_pop0 ? r_actual[r_head]  : 1'b0;
      r_npc1  <= w_pop1 ? r_npc[w_head1]    : '0;
      r_bhr1  <= w_pop1 ? r_bhr[w_head1]    : '0;
      r_act1  <= w_pop1 ? r_actual[w_head1] : 1'b0;
    end
  end

  // ---------------- entry payload ----------------
  always_ff @(posedge clock) begin
    if (!w_recover && ex_resolve_valid && r_valid[ex_resolve_tag])
      r_actual[ex_resolve_tag] <= ex_actual_taken;
    if (w_enq0) begin
      r_npc[r_tail]    <= id_NPC0;
      r_bhr[r_tail]    <= id_bhr0;
      r_pred[r_tail]   <= id_pred_taken0;
      r_actual[r_tail] <= 1'b0;
    end
    if (w_enq1) begin
      r_npc[w_tag1]    <= id_NPC1;
      r_bhr[w_tag1]    <= id_bhr1;
      r_pred[w_tag1]   <= id_pred_taken1;
      r_actual[w_tag1] <= 1'b0;
    end
  end

  assign id_tag0           = r_tail;
  assign id_tag1           = w_tag1;
  assign id_stall          = w_stall;
  assign rob_retire_num    = r_num;
  assign rob_retire_cond0  = r_cond0;
  assign rob_retire_cond1  = r_cond1;
  assign rob_retire_NPC0   = r_npc0;
  assign rob_retire_NPC1   = r_npc1;
  assign rob_retire_BHR0   = r_bhr0;
  assign rob_retire_BHR1   = r_bhr1;
  assign rob_actual_taken0 = r_act0;
  assign rob_actual_taken1 = r_act1;
  assign recover_cond      = r_recover_cond;
  assign recover_bhr       = r_recover_bhr;
  assign err               = r_err;

endmodule
`default_nettype wire

// File: tb/tb_branch_retire_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_retire_queue
//  Purpose  : Directed self-checking bench for branch_retire_queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_branch_retire_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        id_valid0, id_valid1, id_pred_taken0, id_pred_taken1;
  logic [63:0] id_NPC0, id_NPC1;
  logic [5:0]  id_bhr0, id_bhr1;
  logic [3:0]  id_tag0, id_tag1;
  logic        id_stall;
  logic        ex_resolve_valid, ex_actual_taken;
  logic [3:0]  ex_resolve_tag;
  logic        rob_retire_br0, rob_retire_br1;
  logic [1:0]  rob_retire_num;
  logic        rob_retire_cond0, rob_retire_cond1;
  logic [63:0] rob_retire_NPC0, rob_retire_NPC1;
  logic [5:0]  rob_retire_BHR0, rob_retire_BHR1;
  logic        rob_actual_taken0, rob_actual_taken1;
  logic        recover_cond;
  logic [5:0]  recover_bhr;
  logic        err;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  branch_retire_queue #(.DEPTH(16), .IDX_W(4), .BHR_W(6)) dut (
    .clock(clock), .reset(reset),
    .id_valid0(id_valid0), .id_valid1(id_valid1),
    .id_NPC0(id_NPC0), .id_NPC1(id_NPC1),
    .id_bhr0(id_bhr0), .id_bhr1(id_bhr1),
    .id_pred_taken0(id_pred_taken0), .id_pred_taken1(id_pred_taken1),
    .id_tag0(id_tag0), .id_tag1(id_tag1), .id_stall(id_stall),
    .ex_resolve_valid(ex_resolve_valid), .ex_resolve_tag(ex_resolve_tag),
    .ex_actual_taken(ex_actual_taken),
    .rob_retire_br0(rob_retire_br0), .rob_retire_br1(rob_retire_br1),
    .rob_retire_num(rob_retire_num),
    .rob_retire_cond0(rob_retire_cond0), .rob_retire_cond1(rob_retire_cond1),
    .rob_retire_NPC0(rob_retire_NPC0), .rob_retire_NPC1(rob_retire_NPC1),
    .rob_retire_BHR0(rob_retire_BHR0), .rob_retire_BHR1(rob_retire_BHR1),
    .rob_actual_taken0(rob_actual_taken0), .rob_actual_taken1(rob_actual_taken1),
    .recover_cond(recover_cond), .recover_bhr(recover_bhr), .err(err)
  );

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    id_valid0 = 0; id_valid1 = 0; id_NPC0 = '0; id_NPC1 = '0;
    id_bhr0 = '0; id_bhr1 = '0; id_pred_taken0 = 0; id_pred_taken1 = 0;
    ex_resolve_valid = 0; ex_resolve_tag = '0; ex_actual_taken = 0;
    rob_retire_br0 = 0; rob_retire_br1 = 0;
  endtask

  // Inputs are sampled at the posedge; results are viewed 1ns later.
  task automatic tick();
    @(posedge clock); #1;
    idle();
  endtask

  task automatic do_reset();
    idle();
    reset = 0;
    tick(); tick();
    reset = 1;
    #1;
  endtask

  task automatic resolve(input logic [3:0] tag, input logic taken);
    ex_resolve_valid = 1; ex_resolve_tag = tag; ex_actual_taken = taken;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    reset = 0; #1;
    checks++; if (rob_retire_num !== 2'd0 || rob_retire_cond0 !== 1'b0 || recover_cond !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: num=%0d cond0=%0b rc=%0b err=%0b required 0", rob_retire_num, rob_retire_cond0, recover_cond, err); end
    tick(); tick();
    reset = 1; #1;
    checks++; if (id_tag0 !== 4'd0 || id_stall !== 1'b0) begin
      errors++; $display("FAIL reset_release: tag0=%0d stall=%0b required 0/0", id_tag0, id_stall); end
  endtask

  task automatic test_retire_pair();
    id_valid0 = 1; id_NPC0 = 64'h100; id_bhr0 = 6'h05; id_pred_taken0 = 1;
    id_valid1 = 1; id_NPC1 = 64'h104; id_bhr1 = 6'h0B; id_pred_taken1 = 0;
    #1;
    checks++; if (id_tag0 !== 4'd0 || id_tag1 !== 4'd1) begin
      errors++; $display("FAIL pair_tags: got %0d,%0d required 0,1", id_tag0, id_tag1); end
    tick();
    resolve(4'd0, 1'b1);
    resolve(4'd1, 1'b0);
    rob_retire_br0 = 1; rob_retire_br1 = 1;
    tick();
    checks++; if (rob_retire_num !== 2'd2 || rob_retire_cond0 !== 1'b1 || rob_retire_cond1 !== 1'b1) begin
      errors++; $display("FAIL pair_num: num=%0d c0=%0b c1=%0b required 2/1/1", rob_retire_num, rob_retire_cond0, rob_retire_cond1); end
    checks++; if (rob_retire_NPC0 !== 64'h100 || rob_retire_NPC1 !== 64'h104) begin
      errors++; $display("FAIL pair_npc: %0h,%0h required 100,104", rob_retire_NPC0, rob_retire_NPC1); end
    checks++; if (rob_retire_BHR0 !== 6'h05 || rob_retire_BHR1 !== 6'h0B) begin
      errors++; $display("FAIL pair_bhr: %0h,%0h required 05,0b", rob_retire_BHR0, rob_retire_BHR1); end
    checks++; if (rob_actual_taken0 !== 1'b1 || rob_actual_taken1 !== 1'b0 || recover_cond !== 1'b0) begin
      errors++; $display("FAIL pair_actual: a0=%0b a1=%0b rc=%0b required 1/0/0", rob_actual_taken0, rob_actual_taken1, recover_cond); end
    tick();
    checks++; if (rob_retire_num !== 2'd0 || id_tag0 !== 4'd2) begin
      errors++; $display("FAIL pair_after: num=%0d tag0=%0d required 0/2", rob_retire_num, id_tag0); end
  endtask

  task automatic test_mispredict();
    // Head is entry 2 after the previous test.
    id_valid0 = 1; id_NPC0 = 64'h200; id_bhr0 = 6'b101101; id_pred_taken0 = 0;
    id_valid1 = 1; id_NPC1 = 64'h204; id_bhr1 = 6'h00;     id_pred_taken1 = 1;
    tick();
    resolve(4'd2, 1'b1);
    resolve(4'd3, 1'b1);
    rob_retire_br0 = 1; rob_retire_br1 = 1;
    tick();
    checks++; if (rob_retire_num !== 2'd1 || rob_retire_cond0 !== 1'b1 || rob_retire_cond1 !== 1'b0) begin
      errors++; $display("FAIL misp_n1: num=%0d c0=%0b c1=%0b required 1/1/0", rob_retire_num, rob_retire_cond0, rob_retire_cond1); end
    checks++; if (rob_retire_NPC0 !== 64'h200 || rob_actual_taken0 !== 1'b1 || recover_cond !== 1'b0 || id_stall !== 1'b1) begin
      errors++; $display("FAIL misp_n1_data: npc=%0h a0=%0b rc=%0b stall=%0b required 200/1/0/1", rob_retire_NPC0, rob_actual_taken0, recover_cond, id_stall); end
    tick();
    checks++; if (recover_cond !== 1'b1 || recover_bhr !== 6'b011011) begin
      errors++; $display("FAIL misp_n2: rc=%0b bhr=%b required 1/011011", recover_cond, recover_bhr); end
    checks++; if (rob_retire_num !== 2'd0 || rob_retire_cond0 !== 1'b0 || id_stall !== 1'b1) begin
      errors++; $display("FAIL misp_n2_quiet: num=%0d c0=%0b stall=%0b required 0/0/1", rob_retire_num, rob_retire_cond0, id_stall); end
    tick();
    checks++; if (recover_cond !== 1'b0 || id_stall !== 1'b0 || id_tag0 !== 4'd0 || err !== 1'b0) begin
      errors++; $display("FAIL misp_after: rc=%0b stall=%0b tag0=%0d err=%0b required 0/0/0/0", recover_cond, id_stall, id_tag0, err); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int p = 0; p < 7; p++) begin
      id_valid0 = 1; id_NPC0 = 64'h1000 + 64'(8 * p);     id_pred_taken0 = 0;
      id_valid1 = 1; id_NPC1 = 64'h1000 + 64'(8 * p + 4); id_pred_taken1 = 0;
      tick();
    end
    for (int t = 0; t < 14; t++) resolve(4'(t), 1'b0);
    for (int pass = 0; pass < 2; pass++) begin
      checks++; if (id_stall !== 1'b0) begin
        errors++; $display("FAIL wrap_stall pass %0d: got %0b required 0", pass, id_stall); end
      id_valid0 = 1; id_NPC0 = (pass == 0) ? 64'h1038 : 64'h1000; id_pred_taken0 = 0;
      id_valid1 = 1; id_NPC1 = (pass == 0) ? 64'h103C : 64'h1004; id_pred_taken1 = 0;
      rob_retire_br0 = 1; rob_retire_br1 = 1;
      #1;
      checks++; if (id_tag0 !== ((pass == 0) ? 4'd14 : 4'd0) || id_tag1 !== ((pass == 0) ? 4'd15 : 4'd1)) begin
        errors++; $display("FAIL wrap_tags pass %0d: got %0d,%0d", pass, id_tag0, id_tag1); end
      tick();
      checks++; if (rob_retire_num !== 2'd2 || rob_retire_NPC1 !== ((pass == 0) ? 64'h1004 : 64'h100C)) begin
        errors++; $display("FAIL wrap_retire pass %0d: num=%0d npc1=%0h", pass, rob_retire_num, rob_retire_NPC1); end
      if (pass == 0) begin
        resolve(4'd14, 1'b0);
        resolve(4'd15, 1'b0);
      end
    end
    // Count must still be 14: one more allocation brings it to 15 and stalls.
    checks++; if (id_stall !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL wrap_count14: stall=%0b err=%0b required 0/0", id_stall, err); end
    id_valid0 = 1; id_NPC0 = 64'h2000;
    tick();
    checks++; if (id_stall !== 1'b1) begin
      errors++; $display("FAIL wrap_count15: stall=%0b required 1", id_stall); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      id_valid0 = 1; id_NPC0 = 64'(i); #1;
      checks++; if (id_stall !== 1'b0 || id_tag0 !== 4'(i)) begin
        errors++; $display("FAIL full_fill %0d: stall=%0b tag0=%0d", i, id_stall, id_tag0); end
      tick();
    end
    checks++; if (id_stall !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL full_stall: stall=%0b err=%0b required 1/0", id_stall, err); end
    id_valid0 = 1; id_NPC0 = 64'hDEAD;
    tick();
    checks++; if (err !== 1'b1 || id_tag0 !== 4'd15) begin
      errors++; $display("FAIL full_drop: err=%0b tag0=%0d required 1/15", err, id_tag0); end
  endtask

  task automatic test_unresolved();
    do_reset();
    id_valid0 = 1; id_NPC0 = 64'h300; id_pred_taken0 = 0;
    tick();
    checks++; if (err !== 1'b0) begin
      errors++; $display("FAIL unres_pre: err=%0b required 0", err); end
    rob_retire_br0 = 1;
    tick();
    checks++; if (err !== 1'b1 || rob_retire_num !== 2'd1 || rob_retire_NPC0 !== 64'h300) begin
      errors++; $display("FAIL unres_pop: err=%0b num=%0d npc=%0h required 1/1/300", err, rob_retire_num, rob_retire_NPC0); end
    tick(); tick(); tick();
    checks++; if (err !== 1'b1 || recover_cond !== 1'b0) begin
      errors++; $display("FAIL unres_sticky: err=%0b rc=%0b required 1/0", err, recover_cond); end
    do_reset();
    checks++; if (err !== 1'b0) begin
      errors++; $display("FAIL unres_clear: err=%0b required 0", err); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    id_valid0 = 1; id_NPC0 = 64'h400; id_bhr0 = 6'h3F; id_pred_taken0 = 0;
    tick();
    resolve(4'd0, 1'b1);
    rob_retire_br0 = 1;
    tick();   // now in recovery, update port shows the pop
    reset = 0; #1;
    checks++; if (rob_retire_num !== 2'd0 || rob_retire_cond0 !== 1'b0 || rob_retire_NPC0 !== 64'h0 || id_stall !== 1'b0) begin
      errors++; $display("FAIL midreset_now: num=%0d c0=%0b npc=%0h stall=%0b required 0", rob_retire_num, rob_retire_cond0, rob_retire_NPC0, id_stall); end
    tick();
    reset = 1; #1;
    tick();
    checks++; if (recover_cond !== 1'b0 || recover_bhr !== 6'd0 || id_stall !== 1'b0 || id_tag0 !== 4'd0) begin
      errors++; $display("FAIL midreset_after: rc=%0b bhr=%0h stall=%0b tag0=%0d required 0", recover_cond, recover_bhr, id_stall, id_tag0); end
  endtask

  initial begin
    idle();
    #2;
    test_reset();
    test_retire_pair();
    test_mispredict();
    test_wrap();
    test_full();
    test_unresolved();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
